// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART definitions: byte width used by receiver, receive FIFO and transmitter,
// plus the encoding of the receive FIFO's sticky overrun flag.
package uart_rx_fifo_pkg;

    localparam int UART_DATA_W = 8;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

    typedef enum logic {
        OVR_CLEAR = 1'b0,
        OVR_SET   = 1'b1
    } ovr_state_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receive FIFO port bundle: byte strobe from the UART receiver, valid/ready stream
// to the consumer, and status. The FIFO uses the slave modport.
interface uart_rx_fifo_if
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH = 16
);
    localparam int ADDR_W = $clog2(DEPTH);

    uart_byte_t        in_data;
    logic              in_valid;
    uart_byte_t        m_data;
    logic              m_valid;
    logic              m_ready;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic              overrun;
    logic              clear_overrun;

    modport slave (
        input  in_data, in_valid, m_ready, clear_overrun,
        output m_data, m_valid, count, full, empty, overrun
    );

    modport master (
        output in_data, in_valid, m_ready, clear_overrun,
        input  m_data, m_valid, count, full, empty, overrun
    );

endinterface

// File: rtl/uart_rx_fifo_mem.sv
// DEPTH x byte storage: synchronous write, asynchronous read, so it maps to
// distributed RAM and can be shared with the transmit path.
module uart_fifo_mem
    import uart_rx_fifo_pkg::*;
#(
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  uart_byte_t        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output uart_byte_t        rdata
);

    uart_byte_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer behind the UART receiver: first-word-fall-through circular FIFO
// with occupancy count and a sticky overrun flag for bytes dropped while full.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           reset,
    uart_rx_fifo_if.slave  bus
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    ovr_state_t        ovr_state;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic drop;

    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    always_comb begin
        full  = (count == FULL_CNT);
        empty = (count == '0);
        pop   = !empty && bus.m_ready;
        push  = bus.in_valid && (!full || pop);
        drop  = bus.in_valid && full && !pop;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ovr_state <= OVR_CLEAR;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A drop in the same cycle as clear_overrun keeps the flag set.
            if (drop) begin
                ovr_state <= OVR_SET;
            end else if (bus.clear_overrun) begin
                ovr_state <= OVR_CLEAR;
            end
        end
    end

    uart_fifo_mem #(
        .DEPTH(DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push && !reset),
        .waddr (wr_ptr),
        .wdata (bus.in_data),
        .raddr (rd_ptr),
        .rdata (bus.m_data)
    );

    assign bus.m_valid = !empty;
    assign bus.count   = count;
    assign bus.full    = full;
    assign bus.empty   = empty;
    assign bus.overrun = (ovr_state == OVR_SET);

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side byte buffer that sits directly downstream of the UART receiver. It captures each single-cycle data_valid byte pulse into a circular FIFO and presents the bytes to the consumer over a valid/ready stream. It reports occupancy, and it sets a sticky overrun flag when a byte arrives while the buffer is full, because the receiver cannot be back-pressured.

Parameters:
DEPTH, 16, number of byte entries; power of two, minimum 2
ADDR_W, $clog2(DEPTH), pointer width; derived, never overridden

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high
in_data  input  8  byte from receiver (data_out)
in_valid  input  1  one-cycle strobe from receiver (data_valid)
m_data  output  8  head-of-queue byte
m_valid  output  1  head-of-queue byte is valid
m_ready  input  1  consumer accepts head byte
count  output  ADDR_W+1  number of stored bytes, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0
overrun  output  1  sticky: at least one byte has been dropped
clear_overrun  input  1  one-cycle pulse that clears overrun

Behaviour:
Interface: reset reset, synchronous, active-high; clock clk.

Reset:
- wr_ptr, rd_ptr, count and overrun go to 0.
- empty=1, full=0, m_valid=0.
- m_data is don't-care while m_valid=0; the bench must not check it then.
- Storage contents are not reset.
- A reset asserted mid-stream discards all stored bytes. Any in_valid in the reset cycle is ignored.

Handshake:
- push = in_valid && (!full || pop).
- pop = m_valid && m_ready.
- m_valid = !empty.
- m_data = mem[rd_ptr], first-word-fall-through.
- m_data and m_valid must stay stable while m_valid && !m_ready.

Latency:
- A byte pushed in cycle N shows at the head (m_valid=1) in cycle N+1 if the FIFO was empty.
- Back-to-back pops yield 1 byte/cycle.

Pointers:
- ADDR_W-bit pointers, wrap naturally at DEPTH-1 -> 0.
- count is a separate ADDR_W+1-bit register:
  - +1 on push only
  - -1 on pop only
  - unchanged on push and pop together, or on neither.

Boundary conditions:
- Full and in_valid without pop: byte dropped, overrun <= 1. count, pointers and storage unchanged.
- Full and in_valid with pop in the same cycle: byte accepted, count stays DEPTH, no overrun.
- Empty and m_ready: no pop, no pointer movement, count stays 0.
- Empty and in_valid with m_ready: no same-cycle bypass. The byte is written and is visible the next cycle.
- clear_overrun and a new drop in the same cycle: set wins, overrun stays 1.
- full and empty are registered or decoded from count. They must never both be 1.

No state machine beyond the pointer/count datapath. The overrun flag is a two-state (clear/set) register.

Decomposition:
- No shared package types are needed. An optional shared uart_pkg holds the 8-bit byte width constant (UART_DATA_W=8), used by the receiver, this FIFO and the future transmitter.
- One natural sub-module: uart_fifo_mem. It is a DEPTH x 8 storage array with a synchronous write port and an asynchronous read port, so it can map to distributed RAM and be reused on the transmit path.
- All control logic stays in uart_rx_fifo.

Test Plan:
1. Reset, then push 0xA5 with m_ready=0 -> next cycle m_valid=1, m_data=0xA5, count=1, empty=0. Hold 5 cycles: m_data stays 0xA5.
2. Push 0x00..0x0F (16 bytes) with m_ready=0 -> full=1, count=16. Then m_ready=1 -> bytes 0x00..0x0F drained in order, 1/cycle, and after the 16th pop empty=1, count=0.
3. While full, push 0x55 with m_ready=0 -> overrun=1, count=16, head still 0x00, 0x55 never appears at the output. Then clear_overrun pulse -> overrun=0.
4. While full, push 0x77 with m_ready=1 in the same cycle -> count stays 16, overrun=0, 0x77 emerges as the 16th byte after the current head.
5. Run 40 bytes with random m_ready (~50%) and in_valid every 3rd cycle -> output sequence equals input sequence across multiple pointer wraps, overrun=0.
6. Load 5 bytes, assert reset for 1 cycle alongside in_valid=1 -> count=0, empty=1, m_valid=0, overrun=0. The next pushed byte 0x3C is the first output.
